// File: rtl/lsu_gen2_pkg.sv
// Shared constants and types for the per-thread load-store unit.
// Core pipeline encodings, FSM state and fault code enums.
package lsu_pkg;

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_BOUNDS   = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_CONFLICT = 2'b11
    } lsu_fault_t;

    // Counter width able to hold TIMEOUT; a disabled watchdog still needs one bit.
    function automatic int wd_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// Request watchdog: counts stalled valid cycles and flags the cycle that
// would make the stall count reach TIMEOUT.
module lsu_watchdog
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CW = wd_cnt_width(TIMEOUT);

    logic [CW-1:0] r_count;

    // Saturate so a disabled watchdog never wraps.
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires in the stalled cycle that brings the count to TIMEOUT, so valid
    // is high for exactly TIMEOUT cycles before the FSM gives up.
    always_comb begin
        o_expired = (TIMEOUT != 0) && i_count_en && (r_count == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/lsu_gen2.sv
// Per-thread load-store unit: one FSM issues LDR/STR over a valid/ready
// handshake with bounds, conflict and watchdog fault reporting.
module lsu_gen2
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2 ** ADDR_W,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        core_state,
    input  logic              decoded_mem_read_enable,
    input  logic              decoded_mem_write_enable,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              mem_read_valid,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic              mem_read_ready,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write_valid,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_write_ready,
    output logic [1:0]        lsu_state,
    output logic [DATA_W-1:0] lsu_out,
    output logic              lsu_fault,
    output logic [1:0]        lsu_fault_code
);

    lsu_state_t        r_state;
    lsu_fault_t        r_code;
    logic              r_fault;
    logic              r_rd_vld;
    logic              r_wr_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_out;

    logic w_start;
    logic w_conflict;
    logic w_single;
    logic w_oob;
    logic w_ready;
    logic w_count_en;
    logic w_clear;
    logic w_expired;

    always_comb begin
        w_start    = enable && (core_state == CORE_REQUEST);
        w_conflict = decoded_mem_read_enable && decoded_mem_write_enable;
        w_single   = decoded_mem_read_enable ^ decoded_mem_write_enable;
        // Compare the full operand so high bits beyond ADDR_W also fault.
        w_oob      = 64'(rs) >= 64'(MEM_DEPTH);
        w_ready    = (r_rd_vld && mem_read_ready) || (r_wr_vld && mem_write_ready);
        w_count_en = (r_rd_vld || r_wr_vld) && !w_ready;
        w_clear    = (r_state == LSU_IDLE);
    end

    lsu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_count_en (w_count_en),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= LSU_IDLE;
            r_code   <= FAULT_NONE;
            r_fault  <= 1'b0;
            r_rd_vld <= 1'b0;
            r_wr_vld <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_out    <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_start) begin
                        if (w_conflict) begin
                            r_state <= LSU_DONE;
                            r_fault <= 1'b1;
                            r_code  <= FAULT_CONFLICT;
                        end else if (w_single && w_oob) begin
                            r_state <= LSU_DONE;
                            r_fault <= 1'b1;
                            r_code  <= FAULT_BOUNDS;
                        end else if (w_single) begin
                            r_state  <= LSU_REQUESTING;
                            r_addr   <= rs[ADDR_W-1:0];
                            r_rd_vld <= decoded_mem_read_enable;
                            r_wr_vld <= decoded_mem_write_enable;
                            if (decoded_mem_write_enable) begin
                                r_wdata <= rt;
                            end
                        end
                    end
                end
                LSU_REQUESTING, LSU_WAITING: begin
                    // Ready wins over a same-cycle watchdog expiry.
                    if (w_ready) begin
                        r_state  <= LSU_DONE;
                        r_rd_vld <= 1'b0;
                        r_wr_vld <= 1'b0;
                        if (r_rd_vld) begin
                            r_out <= mem_read_data;
                        end
                    end else if (w_expired) begin
                        r_state  <= LSU_DONE;
                        r_rd_vld <= 1'b0;
                        r_wr_vld <= 1'b0;
                        r_fault  <= 1'b1;
                        r_code   <= FAULT_TIMEOUT;
                    end else begin
                        r_state <= LSU_WAITING;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        r_state <= LSU_IDLE;
                        r_fault <= 1'b0;
                        r_code  <= FAULT_NONE;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read_valid    = r_rd_vld;
        mem_read_address  = r_addr;
        mem_write_valid   = r_wr_vld;
        mem_write_address = r_addr;
        mem_write_data    = r_wdata;
        lsu_state         = r_state;
        lsu_out           = r_out;
        lsu_fault         = r_fault;
        lsu_fault_code    = r_code;
    end

endmodule
